// File: rtl/herring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | herring_pkg: shared constants for the PHI2 wait-state generator |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package herring_pkg;

  localparam int unsigned SRC_CLK_HZ = 50_000_000;

  // Encoded so that bit 0 is PHI2 and bit 1 is the stretch flag.
  localparam logic [1:0] ST_LOW     = 2'b00;
  localparam logic [1:0] ST_HIGH    = 2'b01;
  localparam logic [1:0] ST_STRETCH = 2'b11;

  localparam int unsigned CS_SERIAL1 = 6;  // serial card at $F800
  localparam int unsigned CS_BUS_EN  = 7;

  localparam logic [7:0] DEFAULT_SLOW_MASK = 8'b0100_0000;

endpackage
`default_nettype wire

// File: rtl/herring_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | herring_sat_counter: N-bit counter that sticks at all-ones      |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module herring_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/herring_wait_state_gen.sv
`default_nettype none
// +----------------------------------------------------------------+
// | herring_wait_state_gen: PHI2 divider that stretches slow cycles |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module herring_wait_state_gen
  import herring_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = 16,
  parameter int unsigned WAIT_HALVES   = 2,
  parameter logic [7:0]  SLOW_MASK     = DEFAULT_SLOW_MASK,
  parameter bit          STRETCH_READ  = 1'b1,
  parameter bit          STRETCH_WRITE = 1'b1
) (
  input  logic        clk_src,
  input  logic        reset,
  input  logic [7:0]  cs_n,
  input  logic        rw,
  output logic        cpu_clk_in,
  output logic        stretching,
  output logic [15:0] stretch_events
);

  if ((HALF_PERIOD < 2) || (HALF_PERIOD > 255) || (WAIT_HALVES > 15)) begin : g_param_check
    $error("herring_wait_state_gen: HALF_PERIOD must be 2..255 and WAIT_HALVES 0..15");
  end

  localparam logic [7:0]  PH_LAST = 8'(HALF_PERIOD - 1);
  // Wraps to all-ones when WAIT_HALVES is 0, but slow_l can never be set then.
  localparam logic [11:0] ST_LOAD = 12'(WAIT_HALVES * HALF_PERIOD - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  ph_cnt_q, ph_cnt_d;
  logic [11:0] st_cnt_q, st_cnt_d;
  logic        slow_l_q, slow_l_d;
  logic [7:0]  cs_q;
  logic        rw_q;
  logic        slow;
  logic        evt_inc;

  assign slow = (|(~cs_q & SLOW_MASK)) &
                ((rw_q & STRETCH_READ) | (~rw_q & STRETCH_WRITE));

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q + 8'd1;
    st_cnt_d = st_cnt_q;
    slow_l_d = slow_l_q;
    evt_inc  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (ph_cnt_q == PH_LAST) begin
          state_d  = ST_HIGH;
          ph_cnt_d = 8'd0;
          slow_l_d = slow && (WAIT_HALVES != 0);
        end
      end
      ST_HIGH: begin
        if (ph_cnt_q == PH_LAST) begin
          ph_cnt_d = 8'd0;
          if (slow_l_q) begin
            state_d  = ST_STRETCH;
            st_cnt_d = ST_LOAD;
            evt_inc  = 1'b1;
          end else begin
            state_d = ST_LOW;
          end
        end
      end
      ST_STRETCH: begin
        ph_cnt_d = 8'd0;
        st_cnt_d = st_cnt_q - 12'd1;
        if (st_cnt_q == 12'd0) begin
          state_d  = ST_LOW;
          st_cnt_d = 12'd0;
          slow_l_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_LOW;
        ph_cnt_d = 8'd0;
        st_cnt_d = 12'd0;
        slow_l_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state_q  <= ST_LOW;
      ph_cnt_q <= 8'd0;
      st_cnt_q <= 12'd0;
      slow_l_q <= 1'b0;
      cs_q     <= 8'd0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      st_cnt_q <= st_cnt_d;
      slow_l_q <= slow_l_d;
      cs_q     <= cs_n;
      rw_q     <= rw;
    end
  end

  herring_sat_counter #(
    .WIDTH (16)
  ) u_evt_cnt (
    .clk   (clk_src),
    .rst   (reset),
    .inc   (evt_inc),
    .count (stretch_events)
  );

  assign cpu_clk_in = state_q[0];
  assign stretching = state_q[1];

endmodule
`default_nettype wire

// File: tb/tb_herring_wait_state_gen.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_herring_wait_state_gen: bench for the PHI2 wait-state gen    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_herring_wait_state_gen;

  localparam int HP = 4;
  localparam int WH = 2;
  localparam int N  = 320;

  logic        clk_src = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  cs_n    = 8'hFF;
  logic        rw      = 1'b1;
  logic        clk_a, str_a, clk_b, str_b;
  logic [15:0] ev_a, ev_b;

  int errors = 0;
  int checks = 0;

  always #10 clk_src = ~clk_src;

  // u_a stretches reads and writes; u_b stretches reads only.
  herring_wait_state_gen #(
    .HALF_PERIOD(HP), .WAIT_HALVES(WH), .SLOW_MASK(8'h40),
    .STRETCH_READ(1'b1), .STRETCH_WRITE(1'b1)
  ) u_a (
    .clk_src(clk_src), .reset(reset), .cs_n(cs_n), .rw(rw),
    .cpu_clk_in(clk_a), .stretching(str_a), .stretch_events(ev_a)
  );

  herring_wait_state_gen #(
    .HALF_PERIOD(HP), .WAIT_HALVES(WH), .SLOW_MASK(8'h40),
    .STRETCH_READ(1'b1), .STRETCH_WRITE(1'b0)
  ) u_b (
    .clk_src(clk_src), .reset(reset), .cs_n(cs_n), .rw(rw),
    .cpu_clk_in(clk_b), .stretching(str_b), .stretch_events(ev_b)
  );

  typedef struct {
    logic [7:0] cs;
    logic       r;
    int         high_a;
    int         high_b;
  } vec_t;

  vec_t        tbl[7];
  logic [7:0]  rcs[N];
  logic        rrw[N];
  logic [17:0] exp_v[2][N];

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Returns at the negedge where reset is released: sample 0, state LOW.
  task automatic reset_and_release(input logic [7:0] cs, input logic r);
    reset = 1'b1;
    cs_n  = cs;
    rw    = r;
    repeat (2) @(negedge clk_src);
    reset = 1'b0;
  endtask

  task automatic measure(output int ha, output int hb, output int sa_cnt);
    int sa, sb;
    sa = 0; sb = 0; ha = 0; hb = 0; sa_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk_src);
      if (sa == 0 && clk_a) sa = 1;
      if (sa == 1) begin
        if (clk_a) ha++;
        else sa = 2;
      end
      if (sb == 0 && clk_b) sb = 1;
      if (sb == 1) begin
        if (clk_b) hb++;
        else sb = 2;
      end
      if (i < 16 && str_a) sa_cnt++;
    end
  endtask

  // cs_n is low only in the LOW-phase sample bf_k; returns the first PHI2-high run.
  task automatic late_cs(input int bf_k, output int hlen, output logic [15:0] ev);
    int st;
    st = 0; hlen = 0;
    reset_and_release(8'hFF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk_src);
      if (st == 0 && clk_a) st = 1;
      if (st == 1) begin
        if (clk_a) hlen++;
        else st = 2;
      end
      cs_n = (k == bf_k) ? 8'hBF : 8'hFF;
    end
    ev = ev_a;
  endtask

  task automatic put(input int d, input int k, input logic c, input logic s, input int ev);
    if (k < N) exp_v[d][k] = {c, s, 16'(ev)};
  endtask

  initial begin
    int ha, hb, sac, hl;
    logic [15:0] evl;

    // Reset state
    @(negedge clk_src);
    check("reset_a", {clk_a, str_a, ev_a}, 18'h0);
    check("reset_b", {clk_b, str_b, ev_b}, 18'h0);

    // Cadence after release: 4 low, then toggle every 4
    reset_and_release(8'hFF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk_src);
      check("cadence", {clk_a, str_a, ev_a}, {1'((k / HP) % 2), 1'b0, 16'h0});
    end

    // Table: inputs held for whole cycles; expected PHI2-high length per DUT
    tbl[0] = '{8'hFF, 1'b1, 4, 4};
    tbl[1] = '{8'hBF, 1'b1, 12, 12};
    tbl[2] = '{8'hBF, 1'b0, 12, 4};
    tbl[3] = '{8'h3F, 1'b1, 12, 12};
    tbl[4] = '{8'h7F, 1'b1, 4, 4};
    tbl[5] = '{8'h00, 1'b0, 12, 4};
    tbl[6] = '{8'hFE, 1'b0, 4, 4};
    for (int t = 0; t < 7; t++) begin
      reset_and_release(tbl[t].cs, tbl[t].r);
      measure(ha, hb, sac);
      check("tbl_high_a", 18'(ha), 18'(tbl[t].high_a));
      check("tbl_high_b", 18'(hb), 18'(tbl[t].high_b));
      check("tbl_str_a", 18'(sac), 18'((tbl[t].high_a == 12) ? 8 : 0));
      check("tbl_ev_a", {2'b0, ev_a}, 18'((tbl[t].high_a == 12) ? 1 : 0));
      check("tbl_ev_b", {2'b0, ev_b}, 18'((tbl[t].high_b == 12) ? 1 : 0));
    end

    // Late select: only the value held 2 cycles before LOW end matters
    late_cs(3, hl, evl);
    check("late_cs_high", 18'(hl), 18'd4);
    check("late_cs_ev", {2'b0, evl}, 18'd0);
    late_cs(2, hl, evl);
    check("edge_cs_high", 18'(hl), 18'd12);
    check("edge_cs_ev", {2'b0, evl}, 18'd1);

    // Reset 3 cycles into STRETCH aborts at once
    reset_and_release(8'hBF, 1'b1);
    repeat (10) @(negedge clk_src);
    check("pre_abort", {clk_a, str_a, ev_a}, {1'b1, 1'b1, 16'd1});
    #2 reset = 1'b1;
    #1 check("abort", {clk_a, str_a, ev_a}, 18'h0);
    cs_n = 8'hFF;
    @(negedge clk_src);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk_src);
      check("resume", {clk_a, str_a, ev_a}, {1'((k / HP) % 2), 1'b0, 16'h0});
    end

    // Saturation from a preloaded count
    reset_and_release(8'hBF, 1'b1);
    @(negedge clk_src);
    force u_a.u_evt_cnt.count_q = 16'hFFFE;
    @(negedge clk_src);
    release u_a.u_evt_cnt.count_q;
    repeat (5) @(negedge clk_src);
    check("sat_pre", {2'b0, ev_a}, 18'h0FFFE);
    for (int c = 0; c < 3; c++) begin
      repeat ((c == 0) ? 2 : 16) @(negedge clk_src);
      check("sat", {2'b0, ev_a}, 18'h0FFFF);
    end

    // Random inputs against a bus-cycle level model
    for (int k = 0; k < N; k++) begin
      rcs[k] = 8'($urandom);
      rrw[k] = 1'($urandom);
    end
    for (int d = 0; d < 2; d++) begin
      int s, ev, di;
      bit slow;
      s = 0; ev = 0;
      while (s < N) begin
        for (int i = 0; i < HP; i++) put(d, s + i, 1'b0, 1'b0, ev);
        di = s + HP - 2;
        slow = (di < N) && ((~rcs[di] & 8'h40) != 8'h00) && (rrw[di] || d == 0);
        for (int i = 0; i < HP; i++) put(d, s + HP + i, 1'b1, 1'b0, ev);
        if (slow) begin
          if (ev < 16'hFFFF) ev++;
          for (int i = 0; i < WH * HP; i++) put(d, s + 2 * HP + i, 1'b1, 1'b1, ev);
          s += (2 + WH) * HP;
        end else begin
          s += 2 * HP;
        end
      end
    end
    reset_and_release(8'hFF, 1'b1);
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk_src);
      check("rand_a", {clk_a, str_a, ev_a}, exp_v[0][k]);
      check("rand_b", {clk_b, str_b, ev_b}, exp_v[1][k]);
      cs_n = rcs[k];
      rw   = rrw[k];
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
